// File: rtl/mac_tx_pkg.sv
// Shared types and defaults for the MAC transmit FIFO write path.
package mac_tx_pkg;

   localparam int DEF_DW      = 8;
   localparam int DEF_MIN_LEN = 60;
   localparam int DEF_MAX_LEN = 1514;
   localparam int FCNT_W      = 16;
   localparam int EOF_POS     = DEF_DW;

   localparam logic [1:0] S_RUN  = 2'd0;
   localparam logic [1:0] S_PAD  = 2'd1;
   localparam logic [1:0] S_DROP = 2'd2;

   typedef enum logic [1:0] {
      RUN  = S_RUN,
      PAD  = S_PAD,
      DROP = S_DROP
   } tx_state_e;

endpackage

// File: rtl/mac_tx_fifo_writer_if.sv
// Framer byte stream plus FIFO write port; the writer is the slave side.
interface mac_tx_fifo_writer_if #(parameter int DW = 8);
   logic          s_valid;
   logic [DW-1:0] s_data;
   logic          s_last;
   logic          s_ready;
   logic          fifo_wr;
   logic [DW:0]   fifo_wdata;
   logic          fifo_wfull;

   modport slave  (input  s_valid, s_data, s_last, fifo_wfull,
                   output s_ready, fifo_wr, fifo_wdata);
   modport master (output s_valid, s_data, s_last, fifo_wfull,
                   input  s_ready, fifo_wr, fifo_wdata);
endinterface

// File: rtl/mac_len_ctr.sv
// Frame byte counter; at_min/at_max look at the count including the byte being written now.
module mac_len_ctr #(
   parameter int MIN_LEN = 60,
   parameter int MAX_LEN = 1514,
   parameter int CW      = 11
) (
   input  logic wclk,
   input  logic dir_clr_n,
   input  logic inc,
   input  logic clr,
   output logic at_min,
   output logic at_max
);
   logic [CW-1:0] bcnt;
   logic [CW-1:0] bnext;

   // bcnt never exceeds MAX_LEN-1, so bnext cannot overflow CW bits
   assign bnext  = bcnt + CW'(1);
   assign at_min = (bnext >= CW'(MIN_LEN));
   assign at_max = (bnext == CW'(MAX_LEN));

   always_ff @(posedge wclk or negedge dir_clr_n) begin
      if (!dir_clr_n)
         bcnt <= '0;
      else if (clr)
         bcnt <= '0;
      else if (inc)
         bcnt <= bnext;
   end
endmodule

// File: rtl/mac_tx_fifo_writer.sv
// Transmit FIFO writer: pads short frames, truncates long ones, gates writes on full.
// state | meaning
// RUN   | passing framer bytes into the FIFO
// PAD   | writing zero bytes until the frame reaches MIN_LEN
// DROP  | discarding the tail of a truncated frame
module mac_tx_fifo_writer
   import mac_tx_pkg::*;
#(
   parameter int DW      = DEF_DW,
   parameter int MIN_LEN = DEF_MIN_LEN,
   parameter int MAX_LEN = DEF_MAX_LEN
) (
   input  logic                  wclk,
   input  logic                  dir_clr_n,
   mac_tx_fifo_writer_if.slave   bus,
   output logic [FCNT_W-1:0]     frame_cnt,
   output logic                  trunc_err,
   output logic                  pad_active
);
   localparam int CW = $clog2(MAX_LEN + 1);

   tx_state_e state;
   tx_state_e st_nxt;
   logic      ready_c;
   logic      wr_raw;
   logic      eof;
   logic      cnt_inc;
   logic      cnt_clr;
   logic      frame_done;
   logic      trunc_set;
   logic      at_min;
   logic      at_max;

   mac_len_ctr #(
      .MIN_LEN (MIN_LEN),
      .MAX_LEN (MAX_LEN),
      .CW      (CW)
   ) u_len_ctr (
      .wclk      (wclk),
      .dir_clr_n (dir_clr_n),
      .inc       (cnt_inc),
      .clr       (cnt_clr),
      .at_min    (at_min),
      .at_max    (at_max)
   );

   always_comb begin
      st_nxt     = state;
      ready_c    = 1'b0;
      wr_raw     = 1'b0;
      eof        = 1'b0;
      cnt_inc    = 1'b0;
      cnt_clr    = 1'b0;
      frame_done = 1'b0;
      trunc_set  = 1'b0;
      case (state)
         RUN: begin
            ready_c = !bus.fifo_wfull;
            wr_raw  = bus.s_valid && !bus.fifo_wfull;
            // s_last on byte MAX_LEN also satisfies at_min, so it ends normally
            eof     = bus.s_last ? at_min : at_max;
            if (wr_raw) begin
               if (eof) begin
                  cnt_clr    = 1'b1;
                  frame_done = 1'b1;
                  if (!bus.s_last) begin
                     trunc_set = 1'b1;
                     st_nxt    = DROP;
                  end
               end else begin
                  cnt_inc = 1'b1;
                  if (bus.s_last)
                     st_nxt = PAD;
               end
            end
         end
         PAD: begin
            wr_raw = !bus.fifo_wfull;
            eof    = at_min;
            if (wr_raw) begin
               if (at_min) begin
                  cnt_clr    = 1'b1;
                  frame_done = 1'b1;
                  st_nxt     = RUN;
               end else begin
                  cnt_inc = 1'b1;
               end
            end
         end
         DROP: begin
            ready_c = 1'b1;
            if (bus.s_valid && bus.s_last)
               st_nxt = RUN;
         end
         default: st_nxt = RUN;
      endcase
   end

   always_ff @(posedge wclk or negedge dir_clr_n) begin
      if (!dir_clr_n) begin
         state     <= RUN;
         frame_cnt <= '0;
         trunc_err <= 1'b0;
      end else begin
         state     <= st_nxt;
         trunc_err <= trunc_set;
         if (frame_done)
            frame_cnt <= frame_cnt + FCNT_W'(1);
      end
   end

   assign bus.s_ready    = ready_c;
   assign bus.fifo_wr    = wr_raw && dir_clr_n;
   assign bus.fifo_wdata = {eof, (state == RUN) ? bus.s_data : {DW{1'b0}}};
   assign pad_active     = (state == PAD);
endmodule

// File: tb/tb_mac_tx_fifo_writer.sv
// Directed bench for mac_tx_fifo_writer with a frame-level expected-word queue.
module tb_mac_tx_fifo_writer;
   import mac_tx_pkg::*;

   localparam int MIN_L = 60;
   localparam int MAX_L = 1514;

   logic        wclk = 1'b0;
   logic        dir_clr_n = 1'b0;
   logic [15:0] frame_cnt;
   logic        trunc_err;
   logic        pad_active;

   mac_tx_fifo_writer_if #(.DW(8)) bus ();

   mac_tx_fifo_writer dut (
      .wclk       (wclk),
      .dir_clr_n  (dir_clr_n),
      .bus        (bus.slave),
      .frame_cnt  (frame_cnt),
      .trunc_err  (trunc_err),
      .pad_active (pad_active)
   );

   always #5 wclk = ~wclk;

   typedef struct packed {
      logic [8:0] word;
      logic       trunc;
   } exp_t;

   exp_t       q[$];
   int         checks = 0;
   int         errors = 0;
   int         n_wr = 0, n_pad = 0, n_eof = 0, n_trunc = 0;
   int         exp_frames = 0;
   logic       exp_trunc = 1'b0;
   logic [8:0] last_word = '0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // frame-level model: what words a frame of len bytes must produce
   task automatic model_frame(input int len, input logic [7:0] seed);
      int   n;
      exp_t e;
      n = (len > MAX_L) ? MAX_L : len;
      for (int i = 0; i < n; i++) begin
         e.word  = {(i == n - 1) && (len >= MIN_L), 8'(seed + 8'(i))};
         e.trunc = (len > MAX_L);
         q.push_back(e);
      end
      for (int i = len; i < MIN_L; i++) begin
         e.word  = {(i == MIN_L - 1), 8'h00};
         e.trunc = 1'b0;
         q.push_back(e);
      end
   endtask

   always @(negedge wclk) begin
      exp_t e;
      if (dir_clr_n) begin
         chk("frame_cnt", int'(frame_cnt), exp_frames & 16'hffff);
         chk("trunc_err", int'(trunc_err), int'(exp_trunc));
         if (bus.fifo_wfull)
            chk("wr_while_full", int'(bus.fifo_wr), 0);
         if (pad_active) n_pad++;
         if (trunc_err) n_trunc++;
         exp_trunc = 1'b0;
         if (bus.fifo_wr) begin
            n_wr++;
            last_word = bus.fifo_wdata;
            if (bus.fifo_wdata[8]) n_eof++;
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write actual=0x%0h required=none at %0t", bus.fifo_wdata, $time);
            end else begin
               e = q.pop_front();
               chk("wdata", int'(bus.fifo_wdata), int'(e.word));
               if (e.word[8]) exp_frames++;
               exp_trunc = e.trunc && e.word[8];
            end
         end
      end
   end

   task automatic wait_accept();
      int   g;
      logic rdy;
      g = 0;
      do begin
         @(negedge wclk);
         rdy = bus.s_ready;
         @(posedge wclk);
         #1;
         g++;
      end while (!rdy && g < 200);
      if (!rdy) chk("accept_timeout", g, 0);
   endtask

   task automatic send_frame(input int len, input logic [7:0] seed);
      model_frame(len, seed);
      for (int i = 0; i < len; i++) begin
         bus.s_valid = 1'b1;
         bus.s_data  = 8'(seed + 8'(i));
         bus.s_last  = (i == len - 1);
         wait_accept();
      end
   endtask

   task automatic wait_drain();
      int g;
      g = 0;
      bus.s_valid = 1'b0;
      bus.s_last  = 1'b0;
      while (q.size() != 0 && g < 3000) begin
         @(posedge wclk);
         #1;
         g++;
      end
      if (q.size() != 0) chk("drain_timeout", q.size(), 0);
      repeat (2) @(posedge wclk);
      #1;
   endtask

   task automatic hold_full(input logic in_pad);
      bus.fifo_wfull = 1'b1;
      chk("stall_state_pad", int'(pad_active), int'(in_pad));
      repeat (5) begin
         @(negedge wclk);
         chk("stall_wr", int'(bus.fifo_wr), 0);
         chk("stall_ready", int'(bus.s_ready), 0);
         @(posedge wclk);
         #1;
      end
      bus.fifo_wfull = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      int w0, p0, e0, t0;
      bus.s_valid = 1'b0;
      bus.s_data = '0;
      bus.s_last = 1'b0;
      bus.fifo_wfull = 1'b0;
      #1;
      chk("rst_fifo_wr", int'(bus.fifo_wr), 0);
      chk("rst_frame_cnt", int'(frame_cnt), 0);
      chk("rst_trunc_err", int'(trunc_err), 0);
      chk("rst_pad_active", int'(pad_active), 0);
      chk("rst_s_ready", int'(bus.s_ready), 1);
      repeat (2) @(posedge wclk);
      #2 dir_clr_n = 1'b1;
      @(posedge wclk);
      #1;

      // 64-byte frame
      w0 = n_wr; p0 = n_pad; e0 = n_eof;
      send_frame(64, 8'h00);
      wait_drain();
      chk("f64_writes", n_wr - w0, 64);
      chk("f64_eofs", n_eof - e0, 1);
      chk("f64_pad_cycles", n_pad - p0, 0);
      chk("f64_frame_cnt", int'(frame_cnt), 1);

      // 10-byte frame padded to 60
      w0 = n_wr; p0 = n_pad;
      send_frame(10, 8'h01);
      wait_drain();
      chk("f10_writes", n_wr - w0, 60);
      chk("f10_pad_cycles", n_pad - p0, 50);
      chk("f10_last_word", int'(last_word), 'h100);
      chk("f10_frame_cnt", int'(frame_cnt), 2);

      // 1600-byte frame truncated, then a clean frame
      w0 = n_wr; t0 = n_trunc;
      send_frame(1600, 8'h20);
      wait_drain();
      chk("f1600_writes", n_wr - w0, 1514);
      chk("f1600_last_eof", int'(last_word[8]), 1);
      chk("f1600_trunc_pulses", n_trunc - t0, 1);
      chk("f1600_frame_cnt", int'(frame_cnt), 3);
      w0 = n_wr;
      send_frame(60, 8'h55);
      wait_drain();
      chk("after_trunc_writes", n_wr - w0, 60);
      chk("after_trunc_frame_cnt", int'(frame_cnt), 4);

      // full-flag stalls mid-frame and mid-PAD
      w0 = n_wr;
      fork
         send_frame(40, 8'h40);
         begin
            repeat (10) @(posedge wclk);
            #2;
            hold_full(1'b0);
            repeat (35) @(posedge wclk);
            #2;
            hold_full(1'b1);
         end
      join
      wait_drain();
      chk("stall_writes", n_wr - w0, 60);
      chk("stall_frame_cnt", int'(frame_cnt), 5);

      // reset pulse during PAD of a 30-byte frame
      send_frame(30, 8'h80);
      bus.s_valid = 1'b0;
      bus.s_last  = 1'b0;
      repeat (5) @(posedge wclk);
      #1;
      chk("pre_rst_pad", int'(pad_active), 1);
      #1;
      dir_clr_n = 1'b0;
      q.delete();
      exp_frames = 0;
      exp_trunc  = 1'b0;
      #1;
      chk("midrst_fifo_wr", int'(bus.fifo_wr), 0);
      chk("midrst_pad_active", int'(pad_active), 0);
      chk("midrst_frame_cnt", int'(frame_cnt), 0);
      @(posedge wclk);
      #2 dir_clr_n = 1'b1;
      @(posedge wclk);
      #1;
      w0 = n_wr;
      send_frame(60, 8'hC0);
      wait_drain();
      chk("postrst_writes", n_wr - w0, 60);
      chk("postrst_frame_cnt", int'(frame_cnt), 1);

      // two back-to-back 60-byte frames
      w0 = n_wr; e0 = n_eof;
      send_frame(60, 8'h10);
      send_frame(60, 8'hA0);
      wait_drain();
      chk("b2b_writes", n_wr - w0, 120);
      chk("b2b_eofs", n_eof - e0, 2);
      chk("b2b_frame_cnt", int'(frame_cnt), 3);

      chk("queue_empty", q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/mac_tx_fifo_writer.md
Name: mac_tx_fifo_writer

Overview:
- Write-side producer for the MAC transmit async FIFO, clocked by wclk.
- Accepts a byte stream from the transmit framer using a valid/ready/last handshake.
- Pads short frames to MIN_LEN, truncates oversize frames at MAX_LEN, and writes {last, byte} words into the FIFO.
- Gates writes against the FIFO full flag, because the FIFO memory writes on any enable, even when full.

Parameters:
- DW, 8, payload byte width; FIFO word width is DW+1.
- MIN_LEN, 60, minimum frame length in bytes; shorter frames are zero-padded.
- MAX_LEN, 1514, maximum frame length in bytes; longer frames are truncated and the remainder discarded.
- CW, $clog2(MAX_LEN+1), byte counter width (derived; do not override).

Ports:
- wclk  in  1  write-domain clock.
- dir_clr_n  in  1  reset; asynchronous, active-low.
- s_valid  in  1  upstream byte valid.
- s_data  in  DW  upstream byte.
- s_last  in  1  marks the final byte of a frame.
- s_ready  out  1  byte accepted when s_valid && s_ready.
- fifo_wr  out  1  FIFO write enable.
- fifo_wdata  out  DW+1  bit DW = end-of-frame flag; [DW-1:0] = byte.
- fifo_wfull  in  1  FIFO full flag.
- frame_cnt  out  16  frames completed into the FIFO; wraps at 65535→0.
- trunc_err  out  1  one-cycle pulse when a frame is truncated.
- pad_active  out  1  high while in PAD.

Behaviour:
- States: RUN (default), PAD, DROP. Byte counter bcnt is CW bits wide and reset to 0.
- Reset (dir_clr_n low, asynchronous):
  - state = RUN, bcnt = 0, frame_cnt = 0, trunc_err = 0.
  - fifo_wr is forced to 0 combinationally while reset is low.
  - Reset mid-frame abandons the frame; no end-of-frame word is written.
- s_ready:
  - RUN: !fifo_wfull.
  - DROP: 1.
  - PAD: 0.
- fifo_wr (combinational, zero latency):
  - RUN: s_valid && !fifo_wfull.
  - PAD: !fifo_wfull.
  - DROP: 0.
  - Never asserted while fifo_wfull = 1.
- RUN, on an accepted byte (bcnt counts bytes already written):
  - s_last && bcnt+1 >= MIN_LEN: write {1, s_data}; bcnt → 0; frame_cnt += 1; stay in RUN.
  - s_last && bcnt+1 < MIN_LEN: write {0, s_data}; bcnt += 1; go to PAD.
  - !s_last && bcnt+1 == MAX_LEN: write {1, s_data}; frame_cnt += 1; trunc_err pulses next cycle; bcnt → 0; go to DROP.
  - Otherwise: write {0, s_data}; bcnt += 1.
  - s_last on byte MAX_LEN is a normal end of frame, not a truncation.
- PAD:
  - Each cycle with !fifo_wfull, write {bcnt+1 == MIN_LEN, 0}.
  - On the flagged write: frame_cnt += 1, bcnt → 0, go to RUN.
  - fifo_wfull stalls PAD with no write and no count change.
- DROP:
  - Consume and discard bytes; no FIFO writes.
  - An accepted byte with s_last returns to RUN with bcnt = 0.
- A full FIFO stalls RUN and PAD indefinitely without losing state. Upstream must hold s_data stable while s_valid && !s_ready.
- trunc_err and frame_cnt are registered; they update the cycle after the causing write.
- Full-flag timing: fifo_wfull asserts one wclk after the filling write. The counterpart FIFO's capacity of 2^ASIZE entries therefore bounds the back-to-back write burst, with no over-write.

Decomposition:
- Shared package mac_tx_pkg holds:
  - state enum {RUN, PAD, DROP};
  - localparams for EOF bit position (DW) and default MIN_LEN/MAX_LEN;
  - frame_cnt width (16).
- One natural sub-module, mac_len_ctr: the bcnt counter plus the MIN/MAX compare outputs (at_min, at_max). The FSM stays in the top level.

Test Plan:
- Frame of 64 bytes, FIFO never full → 64 writes on consecutive cycles; only word 63 has bit8 = 1; frame_cnt = 1; pad_active never high.
- Frame of 10 bytes 0x01..0x0A → 10 data writes, then 50 zero pad writes; pad_active for 50 cycles; write 60 = 0x100; frame_cnt = 1.
- Frame of 1600 bytes → 1514 writes; write 1514 has bit8 = 1; trunc_err pulses once; remaining 86 bytes are accepted with no writes; the next frame starts cleanly in RUN.
- fifo_wfull held high for 5 cycles mid-frame and mid-PAD → fifo_wr = 0 and s_ready = 0 during the hold; resume with no byte lost or duplicated; word sequence identical to the unstalled run.
- dir_clr_n pulsed low for 1 cycle in the middle of a 30-byte frame (during PAD) → fifo_wr drops immediately; state = RUN, frame_cnt = 0; the next 60-byte frame is written correctly.
- Two back-to-back 60-byte frames with s_valid constantly high → 120 writes, EOF on writes 60 and 120; frame_cnt = 2.
